// File: rtl/deser_queue_top.sv
// Serial-to-parallel deserializer feeding a byte FIFO, single clock domain.
// Define DESER_MSB_FIRST_EN to assemble bytes MSB first (default LSB first).
module deser_queue_top #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    data_in,
  input  logic                    write_in,
  output logic                    data_ready,
  output logic                    status_out,
  input  logic                    enqueue_in,
  input  logic                    dequeue_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [$clog2(DEPTH):0]  len_out
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic {
    ACCEPT = 1'b0,
    HOLD   = 1'b1
  } state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  last_bit;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  pop;
  logic                  push;
  logic                  has_room;

  // Next shift-register value with the incoming serial bit inserted.
  always_comb begin
    shift_next = shift_q;
`ifdef DESER_MSB_FIRST_EN
    shift_next = {shift_q[DATA_WIDTH-2:0], data_in};
`else
    shift_next = {data_in, shift_q[DATA_WIDTH-1:1]};
`endif
  end

  // Handshake qualifiers; a full FIFO still accepts when it pops this edge.
  always_comb begin
    last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));
    pop      = dequeue_in && (len_out != '0);
    has_room = (len_out < LW'(DEPTH)) || pop;
    push     = (state == HOLD) && enqueue_in && has_room;
  end

  // Deserializer FSM with registered ready/status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ACCEPT;
      bit_cnt    <= '0;
      shift_q    <= '0;
      data_ready <= 1'b0;
      status_out <= 1'b1;
    end else begin
      unique case (state)
        ACCEPT: begin
          if (write_in) begin
            shift_q <= shift_next;
            if (last_bit) begin
              bit_cnt    <= '0;
              state      <= HOLD;
              data_ready <= 1'b1;
              status_out <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (push) begin
            state      <= ACCEPT;
            data_ready <= 1'b0;
            status_out <= 1'b1;
          end
        end
        default: begin
          state      <= ACCEPT;
          bit_cnt    <= '0;
          data_ready <= 1'b0;
          status_out <= 1'b1;
        end
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= shift_q;
    end
  end

  // Pointers, occupancy and the registered pop data.
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      len_out  <= '0;
      data_out <= '0;
    end else begin
      if (pop) begin
        data_out <= mem[head];
        head     <= head + PW'(1);
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   len_out <= len_out + LW'(1);
        2'b01:   len_out <= len_out - LW'(1);
        default: len_out <= len_out;
      endcase
    end
  end

endmodule

// File: tb/tb_deser_queue_top.sv
// Testbench for deser_queue_top: directed vector table, corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_deser_queue_top;

  logic       clock;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       data_ready;
  logic       status_out;
  logic       enqueue_in;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic [3:0] len_out;

  int tests = 0;
  int fails = 0;

`ifdef DESER_MSB_FIRST_EN
  localparam logic [7:0] EXP_B2 = 8'hC0;
  localparam bit         MSB    = 1'b1;
`else
  localparam logic [7:0] EXP_B2 = 8'h03;
  localparam bit         MSB    = 1'b0;
`endif

  deser_queue_top dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .data_ready (data_ready),
    .status_out (status_out),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .data_out   (data_out),
    .len_out    (len_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  bit         m_hold = 0;
  int         m_k = 0;
  logic [7:0] m_acc = '0;
  logic [7:0] m_held = '0;
  logic [7:0] m_q[$];
  logic [7:0] m_dout = '0;

  function automatic void model_step(input logic r, d, w, e, q);
    bit pv, sv;
    int pos;
    if (r) begin
      m_hold = 0; m_k = 0; m_acc = '0;
      m_q.delete(); m_dout = '0;
      return;
    end
    pv = q && (m_q.size() > 0);
    sv = m_hold && e && ((m_q.size() < 8) || pv);
    if (pv) m_dout = m_q.pop_front();
    if (sv) begin
      m_q.push_back(m_held);
      m_hold = 0;
    end else if (!m_hold && w) begin
      if (m_k == 0) m_acc = '0;
      pos = MSB ? 7 - m_k : m_k;
      m_acc[pos] = d;
      m_k++;
      if (m_k == 8) begin
        m_k = 0;
        m_hold = 1;
        m_held = m_acc;
      end
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, d, w, e, q);
    @(negedge clock);
    reset = r; data_in = d; write_in = w;
    enqueue_in = e; dequeue_in = q;
    model_step(r, d, w, e, q);
    @(posedge clock);
    #1;
    check("model_ready", {31'd0, data_ready}, {31'd0, m_hold});
    check("model_status", {31'd0, status_out}, {31'd0, !m_hold});
    check("model_len", {28'd0, len_out}, m_q.size());
    check("model_dout", {24'd0, data_out}, {24'd0, m_dout});
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic b;
    for (int k = 0; k < 8; k++) begin
      b = MSB ? v[7-k] : v[k];
      step(1'b0, b, 1'b1, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic       rst, din, wr, enq, deq;
    logic       rdy, sts;
    logic [3:0] len;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, din, wr, enq, deq,
                              input logic rdy, sts,
                              input logic [3:0] len,
                              input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.din = din; v.wr = wr; v.enq = enq; v.deq = deq;
    v.rdy = rdy; v.sts = sts; v.len = len; v.dout = dout;
    vecs.push_back(v);
  endfunction

  initial begin
    logic b1[8];
    logic b2[8];
    vec_t v;
    reset = 1'b0; data_in = 1'b0; write_in = 1'b0;
    enqueue_in = 1'b0; dequeue_in = 1'b0;

    b1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    b2 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    add(1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(0, b1[i], 1, 0, 0, i == 7, i != 7, 0, 8'h00);
    for (int i = 0; i < 5; i++)
      add(0, i[0], 1, 0, 0, 1, 0, 0, 8'h00);
    add(0, 0, 0, 1, 0, 0, 1, 1, 8'h00);
    add(0, 0, 0, 0, 1, 0, 1, 0, 8'hA5);
    for (int i = 0; i < 8; i++)
      add(0, b2[i], 1, 0, 0, i == 7, i != 7, 0, 8'hA5);
    add(0, 0, 0, 1, 0, 0, 1, 1, 8'hA5);
    add(0, 0, 0, 0, 1, 0, 1, 0, EXP_B2);
    add(0, 0, 0, 1, 0, 0, 1, 0, EXP_B2);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.rst, v.din, v.wr, v.enq, v.deq);
      check($sformatf("vec%0d_ready", i), {31'd0, data_ready}, {31'd0, v.rdy});
      check($sformatf("vec%0d_status", i), {31'd0, status_out}, {31'd0, v.sts});
      check($sformatf("vec%0d_len", i), {28'd0, len_out}, {28'd0, v.len});
      check($sformatf("vec%0d_dout", i), {24'd0, data_out}, {24'd0, v.dout});
    end

    // Fill to full, then a held ninth byte
    step(1, 0, 0, 0, 0);
    for (int b = 1; b <= 8; b++) begin
      send_byte(8'(b));
      step(0, 0, 0, 1, 0);
    end
    check("full_len", {28'd0, len_out}, 32'd8);
    send_byte(8'h09);
    for (int i = 0; i < 3; i++)
      step(0, 1'($urandom_range(0, 1)), 1, 1, 0);
    check("full_hold_ready", {31'd0, data_ready}, 32'd1);
    check("full_hold_len", {28'd0, len_out}, 32'd8);

    // Push and pop together while full
    step(0, 0, 0, 1, 1);
    check("fullpp_dout", {24'd0, data_out}, 32'h01);
    check("fullpp_len", {28'd0, len_out}, 32'd8);
    check("fullpp_ready", {31'd0, data_ready}, 32'd0);
    for (int i = 2; i <= 9; i++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("drain%0d", i), {24'd0, data_out}, i);
    end
    check("drain_len", {28'd0, len_out}, 32'd0);

    // Pops on empty
    step(0, 0, 0, 0, 1);
    check("empty_pop_dout", {24'd0, data_out}, 32'h09);
    check("empty_pop_len", {28'd0, len_out}, 32'd0);
    send_byte(8'h55);
    step(0, 0, 0, 1, 1);
    check("empty_pp_len", {28'd0, len_out}, 32'd1);
    check("empty_pp_dout", {24'd0, data_out}, 32'h09);

    // Reset with partial byte and non-empty queue
    send_byte(8'h11);
    step(0, 0, 0, 1, 0);
    send_byte(8'h22);
    step(0, 0, 0, 1, 0);
    check("pre_rst_len", {28'd0, len_out}, 32'd3);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1);
    check("rst_len", {28'd0, len_out}, 32'd0);
    check("rst_dout", {24'd0, data_out}, 32'd0);
    check("rst_status", {31'd0, status_out}, 32'd1);
    send_byte(8'h3C);
    check("post_rst_ready", {31'd0, data_ready}, 32'd1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    check("post_rst_byte", {24'd0, data_out}, 32'h3C);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
